rr_arb8: RTL and testbench



---
 rtl/rr_arb8_pkg.sv | 12 +
 rtl/rr_arb8_if.sv | 25 ++
 rtl/rr_arb8_mux.sv | 32 +++
 rtl/rr_arb8_pick.sv | 26 ++
 rtl/rr_arb8.sv | 104 ++++++++++
 tb/tb_rr_arb8.sv | 156 +++++++++++++++
 6 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared constants and FSM state type for the eight-way round-robin arbiter.
package eel_arb_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb8_if.sv
// Requester/consumer bundle of the arbiter: requests and data words in, granted word out.
interface rr_arb8_if #(
    parameter int WIDTH = 32
);
    import eel_arb_pkg::*;

    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] d [NREQ];
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] dout;
    logic [IDXW-1:0]  sel;
    logic [NREQ-1:0]  ack;

    modport master (
        output req, d, ready,
        input  valid, dout, sel, ack
    );

    modport slave (
        input  req, d, ready,
        output valid, dout, sel, ack
    );

endinterface

// File: rtl/rr_arb8_mux.sv
// Legacy 8:1 word multiplexer that the arbiter drives with its next-grant index.
module MUX8T1 #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       SEL,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    output logic [WIDTH-1:0] DOUT
);

    always_comb begin
        DOUT = D0;
        case (SEL)
            3'd0: DOUT = D0;
            3'd1: DOUT = D1;
            3'd2: DOUT = D2;
            3'd3: DOUT = D3;
            3'd4: DOUT = D4;
            3'd5: DOUT = D5;
            3'd6: DOUT = D6;
            3'd7: DOUT = D7;
            default: DOUT = D0;
        endcase
    end

endmodule

// File: rtl/rr_arb8_pick.sv
// Combinational round-robin picker: first set request bit found scanning from start upward, modulo 8.
module rr_pick8
    import eel_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] start_i,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [IDXW-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit to start_i is the last to win.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        any_o = |req_i;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = start_i + IDXW'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter sharing one 8:1 datapath mux; the granted word is registered
// and handed downstream over valid/ready, with back-to-back grants while requests remain.
module rr_arb8
    import eel_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     CLK,
    input  logic     RST,
    rr_arb8_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] mux_out;
    logic [NREQ-1:0]  elig;
    logic [IDXW-1:0]  scan_start;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_any;
    logic             xfer;
    logic             load;

    rr_pick8 u_pick (
        .req_i   (elig),
        .start_i (scan_start),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    MUX8T1 #(.WIDTH(WIDTH)) u_mux (
        .SEL  (sel_d),
        .D0   (bus.d[0]),
        .D1   (bus.d[1]),
        .D2   (bus.d[2]),
        .D3   (bus.d[3]),
        .D4   (bus.d[4]),
        .D5   (bus.d[5]),
        .D6   (bus.d[6]),
        .D7   (bus.d[7]),
        .DOUT (mux_out)
    );

    // A transfer masks the departing requester and rescans from the slot after it.
    always_comb begin
        xfer       = (state_q == BUSY) && bus.ready && !RST;
        elig       = bus.req;
        scan_start = ptr_q;
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        load       = 1'b0;

        if (xfer) begin
            elig       = bus.req & ~(NREQ'(1) << sel_q);
            scan_start = sel_q + IDXW'(1);
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    ptr_d = sel_q + IDXW'(1);
                    if (pick_any) begin
                        sel_d = pick_idx;
                        load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            if (load) begin
                dout_q <= mux_out;
            end
        end
    end

    assign bus.valid = (state_q == BUSY);
    assign bus.dout  = dout_q;
    assign bus.sel   = sel_q;
    assign bus.ack   = xfer ? (NREQ'(1) << sel_q) : '0;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: hand-computed grant order, holds, wrap and reset-during-transfer.
module tb_rr_arb8;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int assertions = 0;
    int failures   = 0;

    rr_arb8_if #(.WIDTH(32)) bus ();

    rr_arb8 #(.WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic ready);
        bus.req   = req;
        bus.ready = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs(input string tag, input logic valid, input logic [2:0] sel,
                             input logic [31:0] dout);
        checkOutput({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, valid});
        checkOutput({tag, ".sel"},   {29'd0, bus.sel},   {29'd0, sel});
        checkOutput({tag, ".dout"},  bus.dout,           dout);
    endtask

    function automatic logic [31:0] word(input int i);
        return 32'haaaabbb0 + 32'(i);
    endfunction

    initial begin
        bus.req   = '0;
        bus.ready = 1'b0;
        for (int i = 0; i < 8; i++) bus.d[i] = word(i);

        // Reset and idle
        tick();
        tick();
        checkRegs("reset", 1'b0, 3'd0, 32'h0);
        checkOutput("reset.ack", {24'd0, bus.ack}, 32'h0);
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkRegs("idle", 1'b0, 3'd0, 32'h0);
            checkOutput("idle.ack", {24'd0, bus.ack}, 32'h0);
        end

        // Single requester, one-cycle grant latency, drop returns to IDLE
        bus.d[0] = 32'habababab;
        applyStimulus(8'h01, 1'b1);
        checkOutput("single.ack_idle", {24'd0, bus.ack}, 32'h0);
        tick();
        checkRegs("single.grant", 1'b1, 3'd0, 32'habababab);
        applyStimulus(8'h00, 1'b1);
        checkOutput("single.ack", {24'd0, bus.ack}, 32'h01);
        tick();
        checkOutput("single.drop_valid", {31'd0, bus.valid}, 32'h0);
        checkOutput("single.drop_ack", {24'd0, bus.ack}, 32'h0);
        bus.d[0] = word(0);

        // Full rotation with all requests held
        RST = 1'b1;
        tick();
        RST = 1'b0;
        applyStimulus(8'hFF, 1'b1);
        tick();
        for (int k = 0; k < 9; k++) begin
            checkRegs("rotate", 1'b1, 3'(k % 8), word(k % 8));
            checkOutput("rotate.ack", {24'd0, bus.ack}, 32'h1 << (k % 8));
            tick();
        end
        applyStimulus(8'hFF, 1'b0);
        checkRegs("rotate.end", 1'b1, 3'd1, word(1));
        checkOutput("rotate.hold_ack", {24'd0, bus.ack}, 32'h0);

        // Reach SEL=7, then wrap to 0 with REQ=81
        applyStimulus(8'h80, 1'b1);
        checkOutput("wrap.ack1", {24'd0, bus.ack}, 32'h02);
        tick();
        checkRegs("wrap.sel7", 1'b1, 3'd7, word(7));
        applyStimulus(8'h81, 1'b1);
        checkOutput("wrap.ack7", {24'd0, bus.ack}, 32'h80);
        tick();
        checkRegs("wrap.sel0", 1'b1, 3'd0, word(0));

        // Lone stale REQ[7] in its own transfer cycle is not re-granted
        applyStimulus(8'h80, 1'b1);
        checkOutput("stale.ack0", {24'd0, bus.ack}, 32'h01);
        tick();
        checkRegs("stale.sel7", 1'b1, 3'd7, word(7));
        applyStimulus(8'h80, 1'b1);
        checkOutput("stale.ack7", {24'd0, bus.ack}, 32'h80);
        tick();
        applyStimulus(8'h00, 1'b0);
        checkOutput("stale.idle", {31'd0, bus.valid}, 32'h0);

        // Hold with READY=0 while D3 and REQ change
        applyStimulus(8'h08, 1'b0);
        tick();
        checkRegs("hold.grant", 1'b1, 3'd3, word(3));
        for (int c = 0; c < 4; c++) begin
            bus.d[3] = 32'hdead0000 + 32'(c);
            applyStimulus(8'hF0 | 8'(c), 1'b0);
            checkOutput("hold.ack", {24'd0, bus.ack}, 32'h0);
            tick();
            checkRegs("hold", 1'b1, 3'd3, word(3));
        end
        applyStimulus(8'h00, 1'b1);
        checkOutput("hold.release_ack", {24'd0, bus.ack}, 32'h08);
        tick();
        checkOutput("hold.idle", {31'd0, bus.valid}, 32'h0);
        bus.d[3] = word(3);

        // Reset wins over a transfer cycle
        applyStimulus(8'h02, 1'b0);
        tick();
        checkRegs("rst.grant", 1'b1, 3'd1, word(1));
        RST = 1'b1;
        applyStimulus(8'h02, 1'b1);
        checkOutput("rst.ack", {24'd0, bus.ack}, 32'h0);
        tick();
        checkRegs("rst.after", 1'b0, 3'd0, 32'h0);
        RST = 1'b0;
        applyStimulus(8'h10, 1'b1);
        tick();
        checkRegs("rst.regrant", 1'b1, 3'd4, word(4));
        applyStimulus(8'h00, 1'b1);
        checkOutput("rst.regrant_ack", {24'd0, bus.ack}, 32'h10);
        tick();
        checkOutput("rst.final_idle", {31'd0, bus.valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
